// File: rtl/bastim_pkg.sv
// Shared constants and FSM encoding for the channel scheduler.
// Holds NUM_CH/CW defaults and the per-channel update-state enum.
package bastim_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CW_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_RELOAD = 2'd1,
    ST_APPLY       = 2'd2
  } ch_state_e;

endpackage

// File: rtl/bastim_ch_sched_if.sv
// Configuration bus: write strobe, channel select, staged values, busy.
// master drives the write side, slave (scheduler) returns cfg_busy.
interface bastim_ch_sched_if
  import bastim_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CW     = CW_DEF
);

  logic              cfg_wr;
  logic [1:0]        cfg_ch;
  logic [CW-1:0]     cfg_psc;
  logic [CW-1:0]     cfg_arr;
  logic [CW-1:0]     cfg_startcnt;
  logic [NUM_CH-1:0] cfg_busy;

  modport master (
    output cfg_wr, cfg_ch, cfg_psc, cfg_arr, cfg_startcnt,
    input  cfg_busy
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_psc, cfg_arr, cfg_startcnt,
    output cfg_busy
  );

endinterface

// File: rtl/bastim_ch_sched_slice.sv
// One timer channel: run-enable, pending bit, staged->live config FSM.
// Ports: write hit + cfg values in; enable/reload/clear in; live cfg out.
module bastim_ch_sched_slice
  import bastim_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          ch_clk,
  input  logic          ch_rstn,
  input  logic          i_wr,
  input  logic [CW-1:0] i_psc,
  input  logic [CW-1:0] i_arr,
  input  logic [CW-1:0] i_start,
  input  logic          i_sw_en,
  input  logic          i_sw_ar,
  input  logic          i_int_clr,
  input  logic          i_reload,
  output logic          o_en,
  output logic          o_ar,
  output logic [CW-1:0] o_psc,
  output logic [CW-1:0] o_arr,
  output logic [CW-1:0] o_start,
  output logic          o_busy,
  output logic          o_pend
);

  ch_state_e     r_state;
  ch_state_e     w_nxt;
  logic          r_sw_q;
  logic          r_en;
  logic          r_ar;
  logic          r_pend;
  logic [CW-1:0] r_stg_psc;
  logic [CW-1:0] r_stg_arr;
  logic [CW-1:0] r_stg_start;
  logic [CW-1:0] r_psc;
  logic [CW-1:0] r_arr;
  logic [CW-1:0] r_start;
  logic          w_rise;

  assign w_rise = i_sw_en & ~r_sw_q;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_wr) w_nxt = r_en ? ST_WAIT_RELOAD : ST_APPLY;
      end
      ST_WAIT_RELOAD: begin
        if (i_reload || !r_en) w_nxt = ST_APPLY;
      end
      ST_APPLY: w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ch_clk or negedge ch_rstn) begin
    if (!ch_rstn) begin
      r_state     <= ST_IDLE;
      r_sw_q      <= 1'b0;
      r_en        <= 1'b0;
      r_ar        <= 1'b0;
      r_pend      <= 1'b0;
      r_stg_psc   <= '0;
      r_stg_arr   <= '0;
      r_stg_start <= '0;
      r_psc       <= '0;
      r_arr       <= '0;
      r_start     <= '0;
    end else begin
      r_state <= w_nxt;
      r_sw_q  <= i_sw_en;
      r_ar    <= i_sw_ar;
      // a reload beats a same-cycle clear
      r_pend  <= (r_pend & ~i_int_clr) | i_reload;
      // a rising edge restarts even if a one-shot reload coincides
      if (!i_sw_en)
        r_en <= 1'b0;
      else if (w_rise)
        r_en <= 1'b1;
      else if (i_reload && !i_sw_ar)
        r_en <= 1'b0;
      if (i_wr) begin
        r_stg_psc   <= i_psc;
        r_stg_arr   <= i_arr;
        r_stg_start <= i_start;
      end
      // live copy uses pre-edge staging; a write here stays staged
      if (r_state == ST_APPLY) begin
        r_psc   <= r_stg_psc;
        r_arr   <= r_stg_arr;
        r_start <= r_stg_start;
      end
    end
  end

  assign o_en    = r_en;
  assign o_ar    = r_ar;
  assign o_psc   = r_psc;
  assign o_arr   = r_arr;
  assign o_start = r_start;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_pend  = r_pend;

endmodule

// File: rtl/bastim_ch_sched.sv
// Multi-channel timer config scheduler: per-channel slices + shared irq.
// Ports: ch_clk/ch_rstn, cfg bus (if), sw/int controls, live cfg, irq.
module bastim_ch_sched
  import bastim_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic                 ch_clk,
  input  logic                 ch_rstn,
  bastim_ch_sched_if.slave     cfg,
  input  logic [NUM_CH-1:0]    sw_enable,
  input  logic [NUM_CH-1:0]    sw_auto_reload,
  input  logic [NUM_CH-1:0]    int_en,
  input  logic [NUM_CH-1:0]    int_clr,
  input  logic [NUM_CH-1:0]    int_status_ch_reload,
  output logic [NUM_CH-1:0]    ch_tim_enable,
  output logic [NUM_CH-1:0]    ch_auto_reload,
  output logic [NUM_CH*CW-1:0] r_psc,
  output logic [NUM_CH*CW-1:0] r_arr,
  output logic [NUM_CH*CW-1:0] r_startcnt,
  output logic [NUM_CH-1:0]    int_pending,
  output logic                 irq
);

  logic r_irq;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [1:0] CH = 2'(i);
    logic w_hit;

    assign w_hit = cfg.cfg_wr && (cfg.cfg_ch == CH);

    bastim_ch_sched_slice #(.CW(CW)) u_slice (
      .ch_clk    (ch_clk),
      .ch_rstn   (ch_rstn),
      .i_wr      (w_hit),
      .i_psc     (cfg.cfg_psc),
      .i_arr     (cfg.cfg_arr),
      .i_start   (cfg.cfg_startcnt),
      .i_sw_en   (sw_enable[i]),
      .i_sw_ar   (sw_auto_reload[i]),
      .i_int_clr (int_clr[i]),
      .i_reload  (int_status_ch_reload[i]),
      .o_en      (ch_tim_enable[i]),
      .o_ar      (ch_auto_reload[i]),
      .o_psc     (r_psc[i*CW +: CW]),
      .o_arr     (r_arr[i*CW +: CW]),
      .o_start   (r_startcnt[i*CW +: CW]),
      .o_busy    (cfg.cfg_busy[i]),
      .o_pend    (int_pending[i])
    );
  end

  always_ff @(posedge ch_clk or negedge ch_rstn) begin
    if (!ch_rstn) r_irq <= 1'b0;
    else          r_irq <= |(int_pending & int_en);
  end

  assign irq = r_irq;

endmodule
